// File: rtl/sn_stream_gen.sv
// Binary-to-stochastic stream generator: N channels, each B-bit value becomes a 2^B-cycle unipolar
// bitstream built by weighted-binary MUX selection, with optional repeat and odd-channel decorrelation.
module sn_stream_gen #(
    parameter int N = 4,
    parameter int B = 4
) (
    input  logic           i_clk_sng,
    input  logic           i_rst_sng,
    input  logic [N*B-1:0] i_x,
    input  logic           i_start,
    input  logic           i_stop,
    input  logic           i_repeat,
    input  logic           i_decor,
    output logic [N-1:0]   o_sn_bit,
    output logic           o_valid,
    output logic [B-1:0]   o_idx,
    output logic           o_done,
    output logic           o_busy
);

    typedef enum logic {IDLE, GEN} state_t;

    localparam logic [B-1:0] K_LAST = '1;

    state_t         state_q, state_d;
    logic [B-1:0]   k_q, k_d;
    logic [N*B-1:0] x_q, x_d;
    logic           repeat_q, repeat_d;
    logic           decor_q, decor_d;

    function automatic logic [B-1:0] bit_reverse(input logic [B-1:0] v);
        logic [B-1:0] r;
        for (int i = 0; i < B; i++) r[i] = v[B-1-i];
        return r;
    endfunction

    // Trailing-ones count t of j picks value bit B-1-t; the all-ones slot emits 0.
    function automatic logic stream_bit(input logic [B-1:0] xv, input logic [B-1:0] j);
        logic found;
        logic b;
        found = 1'b0;
        b     = 1'b0;
        for (int i = 0; i < B; i++) begin
            if (!found && !j[i]) begin
                found = 1'b1;
                b     = xv[B-1-i];
            end
        end
        return b;
    endfunction

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk_sng) begin
        if (i_rst_sng) begin
            state_q  <= IDLE;
            k_q      <= '0;
            x_q      <= '0;
            repeat_q <= 1'b0;
            decor_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            x_q      <= x_d;
            repeat_q <= repeat_d;
            decor_q  <= decor_d;
        end
    end

    // NOTE: every next-state signal gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        x_d      = x_q;
        repeat_d = repeat_q;
        decor_d  = decor_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d  = GEN;
                    k_d      = '0;
                    x_d      = i_x;
                    repeat_d = i_repeat;
                    decor_d  = i_decor;
                end
            end
            GEN: begin
                if (i_stop) begin
                    state_d = IDLE;
                    k_d     = '0;
                end else if (k_q == K_LAST) begin
                    k_d = '0;
                    if (repeat_q) x_d = i_x;
                    else          state_d = IDLE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                k_d     = '0;
            end
        endcase
    end

    assign o_valid = (state_q == GEN);
    assign o_busy  = o_valid;
    assign o_idx   = k_q;
    assign o_done  = o_valid && (k_q == K_LAST);

    for (genvar c = 0; c < N; c++) begin : g_ch
        logic [B-1:0] j;
        if (c % 2 == 1) begin : g_odd
            assign j = decor_q ? bit_reverse(k_q) : k_q;
        end else begin : g_even
            assign j = k_q;
        end
        assign o_sn_bit[c] = o_valid ? stream_bit(x_q[c*B +: B], j) : 1'b0;
    end

endmodule

// File: tb/tb_sn_stream_gen.sv
// Directed self-checking bench for sn_stream_gen: a 4x4 instance for the main scenarios and a
// 1x2 instance for the short-stream case.
module tb_sn_stream_gen;

    localparam int N = 4;
    localparam int B = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*B-1:0] x;
    logic           start, stop, rep, decor;
    logic [N-1:0]   sn;
    logic           valid, done, busy;
    logic [B-1:0]   idx;

    logic [1:0]     s_x;
    logic           s_start, s_stop, s_rep, s_decor;
    logic [0:0]     s_sn;
    logic           s_valid, s_done, s_busy;
    logic [1:0]     s_idx;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    sn_stream_gen #(.N(N), .B(B)) dut (
        .i_clk_sng(clk), .i_rst_sng(rst), .i_x(x), .i_start(start), .i_stop(stop),
        .i_repeat(rep), .i_decor(decor), .o_sn_bit(sn), .o_valid(valid), .o_idx(idx),
        .o_done(done), .o_busy(busy)
    );

    sn_stream_gen #(.N(1), .B(2)) dut_small (
        .i_clk_sng(clk), .i_rst_sng(rst), .i_x(s_x), .i_start(s_start), .i_stop(s_stop),
        .i_repeat(s_rep), .i_decor(s_decor), .o_sn_bit(s_sn), .o_valid(s_valid), .o_idx(s_idx),
        .o_done(s_done), .o_busy(s_busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic begin_run(input logic [N*B-1:0] xv, input logic r, input logic d);
        x     = xv;
        rep   = r;
        decor = d;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset;
        x   = '1;
        rst = 1'b1;
        tick();
        tick();
        n_total++; if (valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", valid); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %0b want 0", done); else n_pass++;
        n_total++; if (idx !== 4'd0) $display("FAIL reset_idx: got %0d want 0", idx); else n_pass++;
        n_total++; if (sn !== 4'd0) $display("FAIL reset_sn: got %b want 0000", sn); else n_pass++;
        n_total++; if (s_valid !== 1'b0) $display("FAIL reset_small_valid: got %0b want 0", s_valid); else n_pass++;
        rst = 1'b0;
        tick();
        n_total++; if (valid !== 1'b0) $display("FAIL idle_no_start: got %0b want 0", valid); else n_pass++;
    endtask

    task automatic test_popcount;
        int pop[N];
        int vcnt = 0, dcnt = 0, bad_done = 0, bad_ch2 = 0, bad_ch0 = 0, bad_idx = 0, bad_busy = 0;
        for (int c = 0; c < N; c++) pop[c] = 0;
        begin_run({4'd15, 4'd8, 4'd1, 4'd0}, 1'b0, 1'b0);
        n_total++;
        if (valid !== 1'b1 || idx !== 4'd0)
            $display("FAIL first_bit_latency: valid=%0b idx=%0d want valid=1 idx=0", valid, idx);
        else n_pass++;
        for (int cyc = 0; cyc < 24; cyc++) begin
            if (valid === 1'b1) begin
                if (int'(idx) != vcnt) bad_idx++;
                for (int c = 0; c < N; c++) pop[c] += int'(sn[c]);
                if (done !== (idx == 4'd15)) bad_done++;
                if (done === 1'b1) dcnt++;
                if (sn[2] !== ~idx[0]) bad_ch2++;
                if (sn[0] !== 1'b0) bad_ch0++;
                vcnt++;
            end
            if (busy !== valid) bad_busy++;
            tick();
        end
        n_total++; if (vcnt != 16) $display("FAIL pop_valid_len: got %0d want 16", vcnt); else n_pass++;
        n_total++; if (pop[3] != 15) $display("FAIL pop_ch3: got %0d want 15", pop[3]); else n_pass++;
        n_total++; if (pop[2] != 8) $display("FAIL pop_ch2: got %0d want 8", pop[2]); else n_pass++;
        n_total++; if (pop[1] != 1) $display("FAIL pop_ch1: got %0d want 1", pop[1]); else n_pass++;
        n_total++; if (pop[0] != 0) $display("FAIL pop_ch0: got %0d want 0", pop[0]); else n_pass++;
        n_total++; if (dcnt != 1) $display("FAIL pop_done_count: got %0d want 1", dcnt); else n_pass++;
        n_total++; if (bad_done != 0) $display("FAIL pop_done_pos: got %0d bad want 0", bad_done); else n_pass++;
        n_total++; if (bad_ch2 != 0) $display("FAIL pop_ch2_even: got %0d bad want 0", bad_ch2); else n_pass++;
        n_total++; if (bad_ch0 != 0) $display("FAIL pop_ch0_zero: got %0d bad want 0", bad_ch0); else n_pass++;
        n_total++; if (bad_idx != 0) $display("FAIL pop_idx_seq: got %0d bad want 0", bad_idx); else n_pass++;
        n_total++; if (bad_busy != 0) $display("FAIL pop_busy: got %0d bad want 0", bad_busy); else n_pass++;
    endtask

    task automatic test_sequence;
        logic [15:0] obs = '0;
        begin_run({12'd0, 4'b1010}, 1'b0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            obs[k] = sn[0];
            tick();
        end
        n_total++; if (obs !== 16'h5D5D) $display("FAIL seq_1010: got %h want 5d5d", obs); else n_pass++;
        n_total++; if (valid !== 1'b0) $display("FAIL seq_end_idle: got %0b want 0", valid); else n_pass++;
    endtask

    task automatic test_decor;
        logic [15:0] o0 = '0, o1 = '0;
        logic [3:0]  kk, rk;
        int bad_rel = 0;
        begin_run({8'd0, 4'd5, 4'd5}, 1'b0, 1'b1);
        for (int k = 0; k < 16; k++) begin
            o0[k] = sn[0];
            o1[k] = sn[1];
            tick();
        end
        for (int k = 0; k < 16; k++) begin
            kk = 4'(k);
            rk = {kk[0], kk[1], kk[2], kk[3]};
            if (o1[k] !== o0[rk]) bad_rel++;
        end
        n_total++; if (o0 !== 16'h22A2) $display("FAIL decor_ch0: got %h want 22a2", o0); else n_pass++;
        n_total++; if (o1 !== 16'h4F00) $display("FAIL decor_ch1: got %h want 4f00", o1); else n_pass++;
        n_total++; if ($countones(o0) != 5) $display("FAIL decor_pop0: got %0d want 5", $countones(o0)); else n_pass++;
        n_total++; if ($countones(o1) != 5) $display("FAIL decor_pop1: got %0d want 5", $countones(o1)); else n_pass++;
        n_total++; if (o0 === o1) $display("FAIL decor_differ: got equal %h want different", o0); else n_pass++;
        n_total++; if (bad_rel != 0) $display("FAIL decor_bitrev: got %0d bad want 0", bad_rel); else n_pass++;
    endtask

    task automatic test_stop_snapshot;
        logic [15:0] expv = 16'h5D5D;
        int bad_bit = 0, dcnt = 0;
        begin_run({12'd0, 4'b1010}, 1'b0, 1'b0);
        for (int k = 0; k <= 6; k++) begin
            if (sn[0] !== expv[k] || valid !== 1'b1) bad_bit++;
            if (done === 1'b1) dcnt++;
            if (k == 3) x = '1;
            if (k == 6) stop = 1'b1;
            tick();
        end
        stop = 1'b0;
        n_total++; if (bad_bit != 0) $display("FAIL stop_snapshot_bits: got %0d bad want 0", bad_bit); else n_pass++;
        n_total++; if (dcnt != 0) $display("FAIL stop_no_done: got %0d want 0", dcnt); else n_pass++;
        n_total++; if (valid !== 1'b0) $display("FAIL stop_valid: got %0b want 0", valid); else n_pass++;
        n_total++; if (idx !== 4'd0 || sn !== 4'd0) $display("FAIL stop_idle_out: idx=%0d sn=%b want 0", idx, sn); else n_pass++;
    endtask

    task automatic test_repeat;
        int pop1 = 0, pop2 = 0, gap = 0, dcnt = 0, bad_done = 0;
        begin_run({12'd0, 4'd3}, 1'b1, 1'b0);
        for (int cyc = 0; cyc <= 33; cyc++) begin
            if (valid !== 1'b1) gap++;
            if (cyc < 16) pop1 += int'(sn[0]);
            else if (cyc < 32) pop2 += int'(sn[0]);
            if (done === 1'b1) begin
                dcnt++;
                if (idx !== 4'd15) bad_done++;
            end
            if (cyc == 5) x = {12'd0, 4'd12};
            if (cyc == 33) stop = 1'b1;
            tick();
        end
        stop = 1'b0;
        rep  = 1'b0;
        n_total++; if (gap != 0) $display("FAIL rep_gap: got %0d want 0", gap); else n_pass++;
        n_total++; if (pop1 != 3) $display("FAIL rep_pop1: got %0d want 3", pop1); else n_pass++;
        n_total++; if (pop2 != 12) $display("FAIL rep_pop2: got %0d want 12", pop2); else n_pass++;
        n_total++; if (dcnt != 2) $display("FAIL rep_done_count: got %0d want 2", dcnt); else n_pass++;
        n_total++; if (bad_done != 0) $display("FAIL rep_done_pos: got %0d want 0", bad_done); else n_pass++;
        n_total++; if (valid !== 1'b0) $display("FAIL rep_stop: got %0b want 0", valid); else n_pass++;
    endtask

    task automatic test_corners;
        int bad_idx = 0;
        logic [3:0] s_obs = '0;
        int s_bad_done = 0;

        begin_run({N{4'd15}}, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++) tick();
        n_total++; if (idx !== 4'd9) $display("FAIL rst_mid_idx: got %0d want 9", idx); else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_total++;
        if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || idx !== 4'd0 || sn !== 4'd0)
            $display("FAIL rst_mid_out: valid=%0b busy=%0b done=%0b idx=%0d sn=%b want all 0",
                     valid, busy, done, idx, sn);
        else n_pass++;
        tick();
        n_total++; if (valid !== 1'b0) $display("FAIL rst_mid_stay_idle: got %0b want 0", valid); else n_pass++;

        begin_run({12'd0, 4'b1010}, 1'b0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            if (int'(idx) != k) bad_idx++;
            start = (k == 5 || k == 15);
            tick();
        end
        start = 1'b0;
        n_total++; if (bad_idx != 0) $display("FAIL start_in_gen_idx: got %0d bad want 0", bad_idx); else n_pass++;
        n_total++; if (valid !== 1'b0) $display("FAIL start_in_gen_end: got %0b want 0", valid); else n_pass++;

        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        n_total++;
        if (valid !== 1'b1 || idx !== 4'd0)
            $display("FAIL start_stop_idle: valid=%0b idx=%0d want valid=1 idx=0", valid, idx);
        else n_pass++;
        for (int k = 0; k < 16; k++) tick();
        n_total++; if (valid !== 1'b0) $display("FAIL b2b_end: got %0b want 0", valid); else n_pass++;

        s_x     = 2'd3;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            s_obs[k] = s_valid ? s_sn[0] : 1'bx;
            if (s_done !== (k == 3)) s_bad_done++;
            tick();
        end
        n_total++; if (s_obs !== 4'b0111) $display("FAIL small_bits: got %b want 0111", s_obs); else n_pass++;
        n_total++; if (s_bad_done != 0) $display("FAIL small_done: got %0d bad want 0", s_bad_done); else n_pass++;
        n_total++; if (s_valid !== 1'b0) $display("FAIL small_end: got %0b want 0", s_valid); else n_pass++;
    endtask

    initial begin
        rst     = 1'b1;
        x       = '0;
        start   = 1'b0;
        stop    = 1'b0;
        rep     = 1'b0;
        decor   = 1'b0;
        s_x     = '0;
        s_start = 1'b0;
        s_stop  = 1'b0;
        s_rep   = 1'b0;
        s_decor = 1'b0;
        test_reset();
        test_popcount();
        test_sequence();
        test_decor();
        test_stop_snapshot();
        test_repeat();
        test_corners();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sn_stream_gen.md
Name: sn_stream_gen

Overview:
- Parametrised binary-to-stochastic converter: N channels, each converting a B-bit unsigned value into a 2^B-cycle unipolar bitstream.
- Uses weighted-binary MUX selection, so each stream contains exactly x ones.
- Successor to the fixed 4x4-bit generator. Adds a per-stream input snapshot, a continuous (repeat) mode, a decorrelated mode for odd channels, and index/done status.
- Sits between the BN-output stage and the stochastic MAC array.

Parameters:
- N, 4: number of channels.
- B, 4: input width per channel. Stream length L = 2^B. Legal range 2..8.

Ports:
- i_clk_sng  in  1  clock; all state updates on rising edge.
- i_rst_sng  in  1  reset, synchronous, active-high.
- i_x  in  N*B  channel values; channel c at bits [c*B +: B], unsigned.
- i_start  in  1  start request; sampled only in IDLE.
- i_stop  in  1  abort request; sampled only in GEN.
- i_repeat  in  1  mode; sampled together with i_start, held for the run.
- i_decor  in  1  mode; sampled together with i_start, held for the run.
- o_sn_bit  out  N  stream bit per channel; meaningful only when o_valid=1.
- o_valid  out  1  high while in GEN.
- o_idx  out  B  current stream index k.
- o_done  out  1  high on the last bit of each stream (k=L-1).
- o_busy  out  1  equal to o_valid.

Behaviour:
- Reset (synchronous, i_rst_sng=1 at the edge):
  - state=IDLE; k=0; snapshot regs=0; repeat_r=0; decor_r=0.
  - Outputs: o_sn_bit=0, o_valid=0, o_idx=0, o_done=0, o_busy=0.
  - Reset takes priority over everything, including mid-stream; no o_done is emitted.
- States: IDLE, GEN.
- IDLE -> GEN on the edge where i_start=1. At that edge:
  - x_r <= i_x (snapshot);
  - repeat_r <= i_repeat; decor_r <= i_decor;
  - k <= 0.
  - i_stop is ignored in IDLE.
- Latency: the first bit (k=0) appears in the cycle after i_start is sampled.
- GEN, each edge, in priority order:
  - i_stop=1: go to IDLE, k <= 0.
  - k=L-1 and repeat_r=0: go to IDLE, k <= 0.
  - k=L-1 and repeat_r=1: stay in GEN, k <= 0, x_r <= i_x (re-snapshot).
  - otherwise: k <= k+1.
  - i_start is ignored in GEN.
  - i_repeat and i_decor are ignored except at a start.
- Outputs are combinational from registered state:
  - o_valid = (state==GEN); o_idx = k; o_done = o_valid & (k==L-1).
  - The bit shown in the cycle where i_stop is sampled is still valid.
  - If i_stop coincides with k=L-1, o_done is still high in that cycle. The next stream does not start.
- Bit generation per channel c:
  - Effective index j: j = bitrev_B(k) if decor_r=1 and c is odd; otherwise j = k.
  - If j = L-1: bit = 0.
  - Otherwise: t = number of trailing ones in j (0..B-1), and bit = x_r[c][B-1-t].
  - Consequence: bit B-1-t is selected 2^(B-1-t) times per stream, so the popcount over L cycles equals x_r[c] exactly, in both modes. bitrev is a permutation and fixes L-1.
- x_r is stable for a whole stream; changes on i_x mid-stream have no effect until the next snapshot.
- Back-to-back single-shot runs: after the IDLE return, the earliest restart is i_start in the next cycle. That gives one idle cycle with o_valid=0 between streams.
- Outputs in IDLE: o_sn_bit=0 and o_idx=0.

Test Plan:
- Reset then popcount (N=4, B=4): i_x={c3=15, c2=8, c1=1, c0=0}, i_start pulse, i_repeat=0 -> o_valid high exactly 16 cycles. Popcounts 15/8/1/0. o_done only at o_idx=15. Channel-0 bits all 0. For x=8, ones appear exactly at k even (0, 2, 4, ..., 14).
- Sequence check (x=4'b1010, decor=0) -> bits for k=0..15: 1,0,1,1,1,0,1,0,1,0,1,1,1,0,1,0 (sel 3,2,3,1,3,2,3,0,... last slot forced 0).
- Decor mode, x=5 on channels 0 and 1 -> both popcounts 5. Bit patterns differ. Channel-1 bit at k equals channel-0 bit at bitrev(k).
- Stop and snapshot: i_stop at k=6 -> bit for k=6 valid, o_valid=0 from next cycle, no o_done. i_x changed at k=3 -> no effect on the stream.
- Repeat: i_repeat=1, i_x=3 then changed to 12 during the first stream -> second stream popcount 12. o_done pulses at every k=15. Continuous o_valid with no gap. i_stop ends the run.
- Corner cases:
  - Synchronous reset at k=9 -> next cycle all outputs 0, IDLE.
  - i_start while GEN -> ignored.
  - i_start and i_stop together in IDLE -> starts.
  - Re-run with B=2, N=1: x=3 -> bits 1,1,1,0.
